// File: rtl/cvif_pkg.sv
// Shared types and widths for the CVIF read weighted round-robin arbiter.
package cvif_pkg;
  localparam int OS_CNT_W = 9;
  localparam int WEIGHT_W = 8;

  typedef enum logic {
    SEL   = 1'b0,
    GRANT = 1'b1
  } arb_state_e;
endpackage

// File: rtl/nv_nvdla_cvif_rr_pick.sv
// Combinational find-first over a request mask, starting at `start` and wrapping.
module nv_nvdla_cvif_rr_pick #(
  parameter int NUM   = 4,
  parameter int IDX_W = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic [NUM-1:0]   req,
  input  logic [IDX_W-1:0] start,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);
  logic [IDX_W-1:0] j;

  // Walk offsets high to low so the nearest requester to `start` is written last.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    j   = '0;
    for (int k = NUM - 1; k >= 0; k--) begin
      j = IDX_W'((int'(start) + k) % NUM);
      if (req[j]) begin
        hit = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/nv_nvdla_cvif_rd_wrr_arb.sv
// Weighted round-robin arbiter for CVIF read requests with an outstanding-read
// limit and a single registered output slot toward the memory interface.
module nv_nvdla_cvif_rd_wrr_arb
  import cvif_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int PD_W        = 79,
  parameter int ID_W        = 2
) (
  input  logic                            nvdla_core_clk,
  input  logic                            nvdla_core_rstn,
  input  logic [NUM_CLIENTS-1:0]          client_req_valid,
  output logic [NUM_CLIENTS-1:0]          client_req_ready,
  input  logic [NUM_CLIENTS*PD_W-1:0]     client_req_pd,
  input  logic [NUM_CLIENTS*WEIGHT_W-1:0] reg2dp_rd_weight,
  input  logic [7:0]                      reg2dp_rd_os_cnt,
  output logic                            arb2mc_req_valid,
  input  logic                            arb2mc_req_ready,
  output logic [ID_W+PD_W-1:0]            arb2mc_req_pd,
  input  logic                            mc2arb_rsp_done,
  output logic                            dp2reg_idle
);
  localparam int IDX_W = $clog2(NUM_CLIENTS);

  logic [NUM_CLIENTS-1:0][WEIGHT_W-1:0] weight;
  logic [NUM_CLIENTS-1:0][PD_W-1:0]     pd;
  logic [NUM_CLIENTS-1:0]               req_mask;
  arb_state_e                           state, state_nxt;
  logic [IDX_W-1:0]                     cur, start, pick_idx;
  logic [WEIGHT_W-1:0]                  credit;
  logic [OS_CNT_W-1:0]                  os_cnt, os_lim;
  logic                                 pick_hit, slot_free, os_ok, accept, rsp_eff;

  assign weight = reg2dp_rd_weight;
  assign pd     = client_req_pd;

  // Zero-weight clients are invisible to the scan.
  always_comb begin
    for (int i = 0; i < NUM_CLIENTS; i++)
      req_mask[i] = client_req_valid[i] & (weight[i] != '0);
  end

  assign start     = (cur == IDX_W'(NUM_CLIENTS - 1)) ? '0 : cur + 1'b1;
  assign slot_free = !arb2mc_req_valid | arb2mc_req_ready;
  assign os_lim    = {1'b0, reg2dp_rd_os_cnt} + OS_CNT_W'(1);
  assign os_ok     = os_cnt < os_lim;
  assign accept    = client_req_valid[cur] & client_req_ready[cur];
  assign rsp_eff   = mc2arb_rsp_done & (os_cnt != '0);

  nv_nvdla_cvif_rr_pick #(.NUM(NUM_CLIENTS), .IDX_W(IDX_W)) u_pick (
    .req   (req_mask),
    .start (start),
    .hit   (pick_hit),
    .idx   (pick_idx)
  );

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) state <= SEL;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SEL:   if (pick_hit) state_nxt = GRANT;
      GRANT: if (!client_req_valid[cur] || weight[cur] == '0 ||
                 (accept && credit == WEIGHT_W'(1)))
               state_nxt = SEL;
      default: state_nxt = SEL;
    endcase
  end

  always_comb begin
    client_req_ready = '0;
    if (state == GRANT && credit != '0 && slot_free && os_ok && weight[cur] != '0)
      client_req_ready[cur] = 1'b1;
  end

  // Credit is reloaded from the live weight only when a new grant is chosen.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      cur    <= '0;
      credit <= '0;
    end else if (state == SEL && pick_hit) begin
      cur    <= pick_idx;
      credit <= weight[pick_idx];
    end else if (accept) begin
      credit <= credit - 1'b1;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn)        os_cnt <= '0;
    else if (accept && !rsp_eff) os_cnt <= os_cnt + 1'b1;
    else if (!accept && rsp_eff) os_cnt <= os_cnt - 1'b1;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      arb2mc_req_valid <= 1'b0;
      arb2mc_req_pd    <= '0;
    end else if (slot_free) begin
      arb2mc_req_valid <= accept;
      if (accept) arb2mc_req_pd <= {ID_W'(cur), pd[cur]};
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) dp2reg_idle <= 1'b1;
    else dp2reg_idle <= !(|client_req_valid) & !arb2mc_req_valid & (os_cnt == '0);
  end

  a_rsp_underflow: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    !(mc2arb_rsp_done && os_cnt == '0));
endmodule

// File: tb/tb_nv_nvdla_cvif_rd_wrr_arb.sv
// Directed bench for the CVIF read WRR arbiter: grant order, os limit, stalls, masking, reset.
module tb_nv_nvdla_cvif_rd_wrr_arb;
  localparam int N = 4, PD_W = 79, ID_W = 2;

  logic                 clk = 1'b0, rstn = 1'b0;
  logic [N-1:0]         vld, rdy;
  logic [N*PD_W-1:0]    cpd;
  logic [N*8-1:0]       wt;
  logic [7:0]           os;
  logic                 ovld, ordy, done, idle;
  logic [ID_W+PD_W-1:0] opd;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  nv_nvdla_cvif_rd_wrr_arb #(.NUM_CLIENTS(N), .PD_W(PD_W), .ID_W(ID_W)) dut (
    .nvdla_core_clk   (clk),
    .nvdla_core_rstn  (rstn),
    .client_req_valid (vld),
    .client_req_ready (rdy),
    .client_req_pd    (cpd),
    .reg2dp_rd_weight (wt),
    .reg2dp_rd_os_cnt (os),
    .arb2mc_req_valid (ovld),
    .arb2mc_req_ready (ordy),
    .arb2mc_req_pd    (opd),
    .mc2arb_rsp_done  (done),
    .dp2reg_idle      (idle)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input logic [7:0] w3, w2, w1, w0);
    wt = {w3, w2, w1, w0};
  endtask

  function automatic logic [ID_W+PD_W-1:0] exp_pd(input int id, input int pay);
    logic [ID_W-1:0] i2 = ID_W'(id);
    logic [PD_W-1:0] p  = PD_W'(pay);
    return {i2, p};
  endfunction

  task automatic do_reset;
    rstn = 1'b0; vld = '0; ordy = 1'b1; done = 1'b0;
    for (int i = 0; i < N; i++) cpd[i*PD_W +: PD_W] = PD_W'(32'hA000 + i);
    tick; tick;
  endtask

  task automatic test_reset;
    do_reset;
    vld = '1; set_w(1, 1, 1, 1); os = 8'd255;
    tick;
    n_vec++; if (ovld !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", ovld); end
    n_vec++; if (opd !== '0) begin n_err++; $display("FAIL rst_pd got %h want 0", opd); end
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL rst_idle got %b want 1", idle); end
    n_vec++; if (rdy !== '0) begin n_err++; $display("FAIL rst_ready got %b want 0", rdy); end
  endtask

  task automatic test_wrr;
    int exp_id[13] = '{-1, 1, -1, 2, -1, 3, -1, 0, 0, -1, 1, -1, 2};
    do_reset;
    set_w(1, 1, 1, 2); os = 8'd255; vld = '1; ordy = 1'b1;
    rstn = 1'b1;
    for (int c = 0; c < 13; c++) begin
      tick;
      n_vec++;
      if (exp_id[c] < 0) begin
        if (ovld !== 1'b0) begin n_err++; $display("FAIL wrr_bubble cyc %0d got valid %b want 0", c, ovld); end
      end else if (ovld !== 1'b1 || opd !== exp_pd(exp_id[c], 32'hA000 + exp_id[c])) begin
        n_err++;
        $display("FAIL wrr_seq cyc %0d got valid %b pd %h want pd %h", c, ovld, opd,
                 exp_pd(exp_id[c], 32'hA000 + exp_id[c]));
      end
    end
    n_vec++; if (idle !== 1'b0) begin n_err++; $display("FAIL wrr_idle got %b want 0", idle); end
  endtask

  task automatic test_os_limit;
    int acc;
    do_reset;
    set_w(1, 1, 1, 8); os = 8'd1; vld = 4'b0001;
    rstn = 1'b1;
    acc = 0;
    repeat (8) begin tick; acc += int'(|(vld & rdy)); end
    n_vec++; if (acc != 2) begin n_err++; $display("FAIL os_accepts got %0d want 2", acc); end
    n_vec++; if (rdy !== '0) begin n_err++; $display("FAIL os_blocked got %b want 0", rdy); end
    done = 1'b1; tick; done = 1'b0; #1;
    acc = 0;
    repeat (6) begin acc += int'(|(vld & rdy)); tick; end
    n_vec++; if (acc != 1) begin n_err++; $display("FAIL os_after_done got %0d want 1", acc); end
    n_vec++; if (rdy !== '0) begin n_err++; $display("FAIL os_reblocked got %b want 0", rdy); end
    n_vec++; if (dut.os_cnt !== 9'd2) begin n_err++; $display("FAIL os_cnt got %0d want 2", dut.os_cnt); end
  endtask

  task automatic test_same_cycle;
    do_reset;
    set_w(1, 1, 1, 8); os = 8'd2; vld = 4'b0001;
    rstn = 1'b1;
    tick; tick; tick;
    n_vec++; if (dut.os_cnt !== 9'd2) begin n_err++; $display("FAIL sc_pre got %0d want 2", dut.os_cnt); end
    n_vec++; if (rdy !== 4'b0001) begin n_err++; $display("FAIL sc_ready got %b want 0001", rdy); end
    done = 1'b1; tick; done = 1'b0;
    n_vec++; if (dut.os_cnt !== 9'd2) begin n_err++; $display("FAIL sc_hold got %0d want 2", dut.os_cnt); end
    n_vec++; if (ovld !== 1'b1) begin n_err++; $display("FAIL sc_valid got %b want 1", ovld); end
    tick;
    n_vec++; if (dut.os_cnt !== 9'd3) begin n_err++; $display("FAIL sc_post got %0d want 3", dut.os_cnt); end
    n_vec++; if (rdy !== '0) begin n_err++; $display("FAIL sc_blocked got %b want 0", rdy); end
  endtask

  task automatic test_stall;
    do_reset;
    set_w(1, 1, 1, 4); os = 8'd255; vld = 4'b0001; ordy = 1'b0;
    rstn = 1'b1;
    tick;
    n_vec++; if (rdy !== 4'b0001) begin n_err++; $display("FAIL stall_first_ready got %b want 0001", rdy); end
    tick;
    cpd[0 +: PD_W] = PD_W'(32'h5555); #1;
    for (int c = 0; c < 5; c++) begin
      n_vec++;
      if (ovld !== 1'b1 || opd !== exp_pd(0, 32'hA000) || rdy !== '0 || dut.credit !== 8'd3) begin
        n_err++;
        $display("FAIL stall cyc %0d got valid %b pd %h ready %b credit %0d want 1 %h 0000 3",
                 c, ovld, opd, rdy, dut.credit, exp_pd(0, 32'hA000));
      end
      tick;
    end
    ordy = 1'b1; #1;
    n_vec++; if (rdy !== 4'b0001) begin n_err++; $display("FAIL stall_release_ready got %b want 0001", rdy); end
    tick;
    n_vec++; if (opd !== exp_pd(0, 32'h5555)) begin n_err++; $display("FAIL stall_next_pd got %h want %h", opd, exp_pd(0, 32'h5555)); end
  endtask

  task automatic test_weight_mask;
    int beats, bad, n;
    int obs[6];
    int exp_seq[6] = '{1, 1, 1, 0, 0, 1};
    do_reset;
    set_w(1, 1, 0, 2); os = 8'd255; vld = 4'b0011;
    rstn = 1'b1;
    beats = 0; bad = 0;
    repeat (12) begin
      tick;
      if (ovld) begin beats++; if (opd[PD_W +: ID_W] != 0) bad++; end
    end
    n_vec++; if (beats != 8) begin n_err++; $display("FAIL mask_beats got %0d want 8", beats); end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL mask_leak got %0d non-zero ids want 0", bad); end
    wt[15:8] = 8'd3;
    for (int k = 0; k < 6; k++) obs[k] = -1;
    n = 0;
    repeat (12) begin
      tick;
      if (ovld && n < 6) begin obs[n] = int'(opd[PD_W +: ID_W]); n++; end
    end
    for (int k = 0; k < 6; k++) begin
      n_vec++;
      if (obs[k] != exp_seq[k]) begin n_err++; $display("FAIL unmask_seq beat %0d got %0d want %0d", k, obs[k], exp_seq[k]); end
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    set_w(1, 1, 1, 8); os = 8'd255; vld = 4'b0001;
    rstn = 1'b1;
    repeat (4) tick;
    n_vec++; if (dut.os_cnt !== 9'd3) begin n_err++; $display("FAIL mid_os_pre got %0d want 3", dut.os_cnt); end
    rstn = 1'b0; #1;
    n_vec++; if (ovld !== 1'b0 || dut.os_cnt !== 9'd0 || idle !== 1'b1 || rdy !== '0) begin
      n_err++; $display("FAIL mid_async got valid %b os %0d idle %b ready %b want 0 0 1 0", ovld, dut.os_cnt, idle, rdy);
    end
    tick;
    n_vec++; if (ovld !== 1'b0 || idle !== 1'b1) begin n_err++; $display("FAIL mid_held got valid %b idle %b want 0 1", ovld, idle); end
    vld = '1; set_w(1, 1, 1, 1);
    rstn = 1'b1;
    tick;
    n_vec++; if (ovld !== 1'b0) begin n_err++; $display("FAIL mid_restart_bubble got %b want 0", ovld); end
    tick;
    n_vec++; if (ovld !== 1'b1 || opd !== exp_pd(1, 32'hA001)) begin
      n_err++; $display("FAIL mid_restart_first got valid %b pd %h want 1 %h", ovld, opd, exp_pd(1, 32'hA001));
    end
  endtask

  initial begin
    vld = '0; ordy = 1'b1; done = 1'b0; os = '0; wt = '0; cpd = '0;
    test_reset;
    test_wrr;
    test_os_limit;
    test_same_cycle;
    test_stall;
    test_weight_mask;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
